rrat: RTL
=========

# rrat

Retirement register alias table. It sits directly downstream of the reorder buffer and consumes the up-to-SS in-order entries the ROB pops each cycle. For each retiring instruction it records the committed architectural-to-physical mapping and returns the superseded physical register to the free list. It also exposes the full committed map for flush recovery, plus a running retirement count.

## Interface
- SS, 2, commit slots per cycle; slot 0 is the oldest.
- NUM_PREGS, 64, number of physical registers; must be ≥ 32 and a power of two.
- PREG_W, $clog2(NUM_PREGS), derived physical register index width; not overridden.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- commit_valid  in  [SS] x 1  slot i retires this cycle (driven from the ROB pop).
- commit_we  in  [SS] x 1  retiring instruction writes a destination register.
- commit_rd  in  [SS] x 5  architectural destination register.
- commit_pd  in  [SS] x PREG_W  physical register allocated to commit_rd at rename.
- free_valid  out  [SS] x 1  registered; free_pr[i] is returned to the free list.
- free_pr  out  [SS] x PREG_W  registered; superseded physical register.
- rrat_map  out  [32] x PREG_W  committed mapping, driven directly from the table registers.
- retire_count  out  64  registered count of retired instructions.

## Operation
- Table: 32 entries of PREG_W bits. Reset value: map[r] = r for r = 0..31.
- A slot is effective when commit_valid[i] && commit_we[i] && commit_rd[i] != 0.
  - x0 is never remapped or freed.
  - An x0 slot still counts toward retire_count.
- Per effective slot i:
  - old_i = the mapping of commit_rd[i] as seen after all older slots (0..i-1) of the same cycle are applied.
  - The table entry is written with commit_pd[i].
  - free_pr[i] = old_i and free_valid[i] = 1 on the next cycle.
- Same rd in slots j < i in one cycle:
  - Slot i frees commit_pd[j], not the pre-cycle table value.
  - The final table value is commit_pd[i], the youngest.
  - The pre-cycle value is freed by slot j.
- A non-effective slot drives free_valid[i] = 0 next cycle. free_pr[i] is then don't-care; drive 0.
- retire_count += popcount(commit_valid) each cycle. It is 64-bit and wraps modulo 2^64.
- Slots are evaluated independently. A valid younger slot with an invalid older slot is processed as given; this is not an error.
- The block has no stall path: every presented commit is accepted in the same cycle.

## Timing
- Reset (rst high at a clock edge):
  - map[r] = r.
  - free_valid = 0, free_pr = 0.
  - retire_count = 0.
  - Any commit in that cycle is dropped.
- rst has priority over commits in the same cycle.
- Reset mid-stream discards all in-flight free results: free_valid is 0 in the cycle after reset.
- Table update latency: rrat_map reflects cycle-N commits in cycle N+1.
- Free latency: cycle-N commits produce free_valid/free_pr in cycle N+1 and hold them for exactly one cycle.
- Retire-count latency: retire_count reflects cycle-N commits in cycle N+1.
- Same-cycle intra-group forwarding (old_i computation) is combinational from commit_* and the table. There is no bypass from the previous cycle's writes; the registers already hold them.
- Back-to-back cycles writing the same rd must each free the correct value:
  - Cycle N frees the pre-N mapping.
  - Cycle N+1 frees commit_pd from cycle N.

## Test plan
- Reset then idle:
  - rrat_map[5] = 5.
  - free_valid = 00.
  - retire_count = 0.
- Single commit, slot 0: rd=3, pd=40.
  - Next cycle: free_valid[0] = 1, free_pr[0] = 3, rrat_map[3] = 40.
  - retire_count = 1.
- Dual commit, same rd: slot 0 rd=7 pd=33, slot 1 rd=7 pd=34.
  - Next cycle: free_pr[0] = 7, free_pr[1] = 33, both free_valid set.
  - rrat_map[7] = 34.
  - retire_count = 2.
- x0 and no-write slots: slot 0 rd=0 we=1 pd=50; slot 1 we=0.
  - free_valid = 00.
  - rrat_map[0] = 0.
  - retire_count += 2.
- Back-to-back same rd:
  - Cycle 1: rd=9 pd=41. Cycle 2: rd=9 pd=42.
  - Frees are 9, then 41.
  - rrat_map[9] = 42 after cycle 2.
- Reset asserted in the same cycle as a commit (rd=4 pd=60):
  - Next cycle: rrat_map[4] = 4, free_valid = 00, retire_count = 0.

Source files
------------

// File: rtl/rrat.sv
// rrat: retirement alias table recording committed arch->phys mappings, freeing superseded pregs.
module rrat #(
  parameter int SS = 2,
  parameter int NUM_PREGS = 64,
  parameter int PREG_W = $clog2(NUM_PREGS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SS-1:0]             commit_valid,
  input  logic [SS-1:0]             commit_we,
  input  logic [SS-1:0][4:0]        commit_rd,
  input  logic [SS-1:0][PREG_W-1:0] commit_pd,
  output logic [SS-1:0]             free_valid,
  output logic [SS-1:0][PREG_W-1:0] free_pr,
  output logic [31:0][PREG_W-1:0]   rrat_map,
  output logic [63:0]               retire_count
);
  logic [31:0][PREG_W-1:0] map_n;
  logic [SS-1:0][PREG_W-1:0] old;
  logic [SS-1:0] eff;
  logic [63:0] cnt;
  // Slots apply oldest-first so a younger slot sees older same-cycle writes.
  always_comb begin
    map_n = rrat_map;
    old = '0;
    eff = '0;
    cnt = '0;
    for (int i = 0; i < SS; i++) begin
      eff[i] = commit_valid[i] && commit_we[i] && commit_rd[i] != 5'd0;
      old[i] = eff[i] ? map_n[commit_rd[i]] : '0;
      if (eff[i]) map_n[commit_rd[i]] = commit_pd[i];
      cnt = cnt + 64'(commit_valid[i]);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) rrat_map[r] <= PREG_W'(r);
      free_valid <= '0;
      free_pr <= '0;
      retire_count <= '0;
    end else begin
      rrat_map <= map_n;
      free_valid <= eff;
      free_pr <= old;
      retire_count <= retire_count + cnt;
    end
  end
endmodule
